// File: rtl/data_lane_ctrl.sv
// DSI data-lane byte-clock sequencer: LP-11 -> LP-01 -> LP-00 -> HS-zero -> sync 0xB8 -> payload -> trail -> LP-11.
// Optional burst/byte statistics outputs are built when DATA_LANE_CTRL_STATS_EN is defined.
module data_lane_ctrl #(
    parameter int unsigned T_LPX   = 6'd2,
    parameter int unsigned T_PREP  = 6'd3,
    parameter int unsigned T_ZERO  = 6'd6,
    parameter int unsigned T_TRAIL = 6'd4,
    parameter int unsigned T_EXIT  = 6'd4
) (
    input  logic        byte_clk,
    input  logic        byte_rst_n,
    input  logic        tx_req,
    input  logic [7:0]  tx_data,
    input  logic        tx_valid,
    input  logic        tx_last,
    output logic        tx_ready,
    output logic        busy,
    output logic        underrun,
    output logic [7:0]  hs_data,
    output logic        hs_enable,
    output logic        hs_hi_z,
    output logic        lp_p,
`ifdef DATA_LANE_CTRL_STATS_EN
    output logic        lp_n,
    output logic [15:0] burst_cnt,
    output logic [15:0] byte_cnt
`else
    output logic        lp_n
`endif
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LPX   = 3'd1,
        PREP  = 3'd2,
        ZERO  = 3'd3,
        SYNC  = 3'd4,
        DATA  = 3'd5,
        TRAIL = 3'd6,
        EXIT  = 3'd7
    } state_t;

    localparam logic [7:0] LPX_LOAD_C   = 8'(T_LPX - 1);
    localparam logic [7:0] PREP_LOAD_C  = 8'(T_PREP - 1);
    localparam logic [7:0] ZERO_LOAD_C  = 8'(T_ZERO - 1);
    localparam logic [7:0] TRAIL_LOAD_C = 8'(T_TRAIL - 1);
    localparam logic [7:0] EXIT_LOAD_C  = 8'(T_EXIT - 1);
    localparam logic [7:0] SYNC_BYTE_C  = 8'hB8;

    state_t     state_r, state_s;
    logic [7:0] timer_r, timer_s;
    logic [7:0] last_byte_r, last_byte_s;
    logic       ready_s, underrun_s, accept_s;
    logic       lp_p_s, lp_n_s, hi_z_s, enable_s;
    logic [7:0] hs_data_s;

    // Next-state, timer and byte-capture logic.
    // The accept window opens with SYNC so each byte lands on hs_data in the DATA cycle after it is taken.
    always_comb begin
        state_s     = state_r;
        timer_s     = timer_r;
        last_byte_s = last_byte_r;
        ready_s     = 1'b0;
        underrun_s  = 1'b0;
        accept_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (tx_req) begin
                    state_s = LPX;
                    timer_s = LPX_LOAD_C;
                end else begin
                    timer_s = 8'd0;
                end
            end
            LPX: begin
                if (timer_r == 8'd0) begin
                    state_s = PREP;
                    timer_s = PREP_LOAD_C;
                end else begin
                    timer_s = timer_r - 8'd1;
                end
            end
            PREP: begin
                if (timer_r == 8'd0) begin
                    state_s = ZERO;
                    timer_s = ZERO_LOAD_C;
                end else begin
                    timer_s = timer_r - 8'd1;
                end
            end
            ZERO: begin
                if (timer_r == 8'd0) begin
                    state_s     = SYNC;
                    timer_s     = 8'd0;
                    ready_s     = 1'b1;
                    last_byte_s = SYNC_BYTE_C;
                end else begin
                    timer_s = timer_r - 8'd1;
                end
            end
            SYNC, DATA: begin
                if (tx_ready && tx_valid) begin
                    accept_s    = 1'b1;
                    last_byte_s = tx_data;
                    state_s     = DATA;
                    ready_s     = ~tx_last;
                end else if (tx_ready) begin
                    // HS lane cannot stall: a missing byte ends the burst.
                    underrun_s = 1'b1;
                    state_s    = TRAIL;
                    timer_s    = TRAIL_LOAD_C;
                end else begin
                    state_s = TRAIL;
                    timer_s = TRAIL_LOAD_C;
                end
            end
            TRAIL: begin
                if (timer_r == 8'd0) begin
                    state_s = EXIT;
                    timer_s = EXIT_LOAD_C;
                end else begin
                    timer_s = timer_r - 8'd1;
                end
            end
            EXIT: begin
                if (timer_r == 8'd0) begin
                    state_s = IDLE;
                    timer_s = 8'd0;
                end else begin
                    timer_s = timer_r - 8'd1;
                end
            end
            default: begin
                state_s = IDLE;
                timer_s = 8'd0;
            end
        endcase
    end

    // Output decode from the next state so pins change on the state-entry edge.
    always_comb begin
        lp_p_s    = 1'b0;
        lp_n_s    = 1'b0;
        hi_z_s    = 1'b1;
        enable_s  = 1'b0;
        hs_data_s = 8'h00;
        case (state_s)
            IDLE, EXIT: begin
                lp_p_s = 1'b1;
                lp_n_s = 1'b1;
            end
            LPX: begin
                lp_n_s = 1'b1;
            end
            PREP: begin
                hi_z_s = 1'b1;
            end
            ZERO: begin
                hi_z_s   = 1'b0;
                enable_s = 1'b1;
            end
            SYNC: begin
                hi_z_s    = 1'b0;
                enable_s  = 1'b1;
                hs_data_s = SYNC_BYTE_C;
            end
            DATA: begin
                hi_z_s    = 1'b0;
                enable_s  = 1'b1;
                hs_data_s = accept_s ? tx_data : 8'h00;
            end
            TRAIL: begin
                hi_z_s    = 1'b0;
                enable_s  = 1'b1;
                hs_data_s = last_byte_s[7] ? 8'h00 : 8'hFF;
            end
            default: begin
                lp_p_s = 1'b1;
                lp_n_s = 1'b1;
            end
        endcase
    end

    // State, timer and registered pin outputs.
    always_ff @(posedge byte_clk or negedge byte_rst_n) begin
        if (!byte_rst_n) begin
            state_r     <= IDLE;
            timer_r     <= 8'd0;
            last_byte_r <= 8'h00;
            lp_p        <= 1'b1;
            lp_n        <= 1'b1;
            hs_hi_z     <= 1'b1;
            hs_enable   <= 1'b0;
            hs_data     <= 8'h00;
            tx_ready    <= 1'b0;
            busy        <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            state_r     <= state_s;
            timer_r     <= timer_s;
            last_byte_r <= last_byte_s;
            lp_p        <= lp_p_s;
            lp_n        <= lp_n_s;
            hs_hi_z     <= hi_z_s;
            hs_enable   <= enable_s;
            hs_data     <= hs_data_s;
            tx_ready    <= ready_s;
            busy        <= (state_s != IDLE);
            underrun    <= underrun_s;
        end
    end

`ifdef DATA_LANE_CTRL_STATS_EN
    // Burst counter wraps; byte counter saturates and restarts with each burst.
    always_ff @(posedge byte_clk or negedge byte_rst_n) begin
        if (!byte_rst_n) begin
            burst_cnt <= 16'd0;
            byte_cnt  <= 16'd0;
        end else begin
            if (state_r == EXIT && state_s == IDLE) begin
                burst_cnt <= burst_cnt + 16'd1;
            end else begin
                burst_cnt <= burst_cnt;
            end
            if (state_r == IDLE && state_s == LPX) begin
                byte_cnt <= 16'd0;
            end else if (accept_s && byte_cnt != 16'hFFFF) begin
                byte_cnt <= byte_cnt + 16'd1;
            end else begin
                byte_cnt <= byte_cnt;
            end
        end
    end
`endif

endmodule

// File: tb/tb_data_lane_ctrl.sv
// Scoreboard bench for data_lane_ctrl: per-cycle expected pin states are queued per burst and popped each cycle.
// Statistics checks are compiled in when DATA_LANE_CTRL_STATS_EN is defined.
module tb_data_lane_ctrl;

    localparam int N_LPX   = 2;
    localparam int N_PREP  = 3;
    localparam int N_ZERO  = 6;
    localparam int N_TRAIL = 4;
    localparam int N_EXIT  = 4;

    logic       byte_clk   = 1'b0;
    logic       byte_rst_n = 1'b0;
    logic       tx_req     = 1'b0;
    logic [7:0] tx_data    = 8'h00;
    logic       tx_valid   = 1'b0;
    logic       tx_last    = 1'b0;
    logic       tx_ready, busy, underrun, hs_enable, hs_hi_z, lp_p, lp_n;
    logic [7:0] hs_data;
`ifdef DATA_LANE_CTRL_STATS_EN
    logic [15:0] burst_cnt, byte_cnt;
    int          burst_exp = 0;
`endif

    typedef struct packed {
        logic       lp_p;
        logic       lp_n;
        logic       hi_z;
        logic       en;
        logic [7:0] data;
        logic       busy;
        logic       ready;
        logic       urun;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       obs_s;
    logic [7:0] pay [4];
    int         total = 0;
    int         bad   = 0;

    data_lane_ctrl dut (
        .byte_clk   (byte_clk),
        .byte_rst_n (byte_rst_n),
        .tx_req     (tx_req),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_last    (tx_last),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .underrun   (underrun),
        .hs_data    (hs_data),
        .hs_enable  (hs_enable),
        .hs_hi_z    (hs_hi_z),
        .lp_p       (lp_p),
`ifdef DATA_LANE_CTRL_STATS_EN
        .lp_n       (lp_n),
        .burst_cnt  (burst_cnt),
        .byte_cnt   (byte_cnt)
`else
        .lp_n       (lp_n)
`endif
    );

    always #5 byte_clk = ~byte_clk;

    assign obs_s = {lp_p, lp_n, hs_hi_z, hs_enable, hs_data, busy, tx_ready, underrun};

    task automatic push(input exp_t e, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(e);
    endtask

    // n = bytes in the burst, n_send = bytes offered before tx_valid drops (n_send < n means underrun).
    task automatic run_burst(input string name, input int n, input int n_send, input logic hold);
        int         idx = 0;
        int         cyc = 0;
        logic       rdy = 1'b0;
        logic       urun;
        logic [7:0] lastb, trail;
        exp_t       e;
        urun  = (n_send < n);
        lastb = (n_send == 0) ? 8'hB8 : pay[n_send-1];
        trail = lastb[7] ? 8'h00 : 8'hFF;
        push({1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0}, N_LPX);
        push({1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0}, N_PREP);
        push({1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0}, N_ZERO);
        push({1'b0, 1'b0, 1'b0, 1'b1, 8'hB8, 1'b1, 1'b1, 1'b0}, 1);
        for (int k = 0; k < n_send; k++)
            push({1'b0, 1'b0, 1'b0, 1'b1, pay[k], 1'b1, (urun || k < n - 1), 1'b0}, 1);
        push({1'b0, 1'b0, 1'b0, 1'b1, trail, 1'b1, 1'b0, urun}, 1);
        push({1'b0, 1'b0, 1'b0, 1'b1, trail, 1'b1, 1'b0, 1'b0}, N_TRAIL - 1);
        push({1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0}, N_EXIT);
        push({1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0}, 1);
        tx_data  = pay[0];
        tx_valid = (n_send > 0);
        tx_last  = (n == 1 && n_send == 1);
        tx_req   = 1'b1;
        while (exp_q.size() > 0) begin
            @(posedge byte_clk);
            #1;
            if (!hold) tx_req = 1'b0;
            if (rdy && tx_valid) begin
                idx++;
                if (idx < n_send) begin
                    tx_data = pay[idx];
                    tx_last = (idx == n - 1);
                end else begin
                    tx_valid = 1'b0;
                    tx_last  = 1'b0;
                end
            end
            @(negedge byte_clk);
            e = exp_q.pop_front();
            total++;
            if (obs_s !== e) begin
                bad++;
                $display("FAIL %s cycle %0d: got %h required %h", name, cyc, obs_s, e);
            end
            rdy = tx_ready;
            cyc++;
        end
`ifdef DATA_LANE_CTRL_STATS_EN
        burst_exp++;
        total++;
        if (burst_cnt !== 16'(burst_exp) || byte_cnt !== 16'(n_send)) begin
            bad++;
            $display("FAIL %s stats: got burst=%0d bytes=%0d required burst=%0d bytes=%0d",
                     name, burst_cnt, byte_cnt, burst_exp, n_send);
        end
`endif
    endtask

    task automatic test_reset();
        exp_t idle_e;
        idle_e = {1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        byte_rst_n = 1'b0;
        #12;
        total++;
        if (obs_s !== idle_e) begin
            bad++;
            $display("FAIL reset_state: got %h required %h", obs_s, idle_e);
        end
`ifdef DATA_LANE_CTRL_STATS_EN
        total++;
        if (burst_cnt !== 16'd0 || byte_cnt !== 16'd0) begin
            bad++;
            $display("FAIL reset_stats: got %0d/%0d required 0/0", burst_cnt, byte_cnt);
        end
`endif
        @(negedge byte_clk);
        byte_rst_n = 1'b1;
        @(negedge byte_clk);
    endtask

    task automatic test_reset_mid();
        int   acc  = 0;
        int   cyc  = 0;
        logic rdy  = 1'b0;
        exp_t idle_e;
        idle_e   = {1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        tx_data  = 8'h11;
        tx_valid = 1'b1;
        tx_last  = 1'b0;
        tx_req   = 1'b1;
        while (!(acc == 2 && hs_data == 8'h22) && cyc < 40) begin
            @(posedge byte_clk);
            #1;
            tx_req = 1'b0;
            if (rdy) begin
                acc++;
                tx_data = (acc == 1) ? 8'h22 : 8'h33;
            end
            @(negedge byte_clk);
            rdy = tx_ready;
            cyc++;
        end
        total++;
        if (cyc >= 40) begin
            bad++;
            $display("FAIL mid_reset_reach_data: got cycles=%0d required <40", cyc);
        end
        #2;
        byte_rst_n = 1'b0;
        #1;
        total++;
        if (obs_s !== idle_e) begin
            bad++;
            $display("FAIL mid_reset_async: got %h required %h", obs_s, idle_e);
        end
`ifdef DATA_LANE_CTRL_STATS_EN
        burst_exp = 0;
`endif
        tx_valid = 1'b0;
        @(negedge byte_clk);
        byte_rst_n = 1'b1;
        repeat (2) @(negedge byte_clk);
        total++;
        if (obs_s !== idle_e) begin
            bad++;
            $display("FAIL mid_reset_idle: got %h required %h", obs_s, idle_e);
        end
    endtask

    task automatic test_basic();
        pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h83; pay[3] = 8'h00;
        run_burst("basic_3byte", 3, 3, 1'b0);
    endtask

    task automatic test_single();
        pay[0] = 8'h7F;
        run_burst("single_7f", 1, 1, 1'b0);
    endtask

    task automatic test_underrun();
        pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h44;
        run_burst("underrun_after_2", 3, 2, 1'b0);
        pay[0] = 8'h55;
        run_burst("underrun_no_byte", 1, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        pay[0] = 8'hC3;
        run_burst("b2b_first", 1, 1, 1'b1);
        pay[0] = 8'h3C;
        run_burst("b2b_second", 1, 1, 1'b1);
        pay[0] = 8'hA5;
        run_burst("b2b_third", 1, 1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_single();
        test_underrun();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
